// File: rtl/wb_pkg.sv
// Shared types and helpers for the pcore writeback stage: load opcodes,
// buffered-load entry layout and the load alignment/extension function.
package wb_pkg;

    localparam int WB_XLEN      = 32;
    localparam int WB_RF_AWIDTH = 5;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } ld_ops_e;

    typedef struct packed {
        logic                    valid;
        logic [WB_RF_AWIDTH-1:0] rd_addr;
        logic [WB_XLEN-1:0]      data;
    } wb_entry_s;

    // Halfword loads select their half with lsb[1] only; misalignment is not flagged.
    function automatic logic [WB_XLEN-1:0] fmt_load(
        input logic [WB_XLEN-1:0] data,
        input logic [2:0]         ops,
        input logic [1:0]         lsb
    );
        logic [WB_XLEN-1:0] word;
        logic [7:0]         byte_v;
        logic [15:0]        half_v;
        logic [WB_XLEN-1:0] res;
        word   = data >> {lsb, 3'b000};
        byte_v = word[7:0];
        half_v = lsb[1] ? data[31:16] : data[15:0];
        case (ld_ops_e'(ops))
            LD_B:    res = {{(WB_XLEN-8){byte_v[7]}}, byte_v};
            LD_H:    res = {{(WB_XLEN-16){half_v[15]}}, half_v};
            LD_BU:   res = {{(WB_XLEN-8){1'b0}}, byte_v};
            LD_HU:   res = {{(WB_XLEN-16){1'b0}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Writeback stage bus: execute result, LSU load response, register-file
// write port and the pending-load count reported back to decode.
interface wb_unit_if
    import wb_pkg::*;
#(
    parameter int XLEN          = WB_XLEN,
    parameter int RF_AWIDTH     = WB_RF_AWIDTH,
    parameter int LSU_BUF_DEPTH = 2
);
    localparam int CNT_W = $clog2(LSU_BUF_DEPTH) + 1;

    logic                 exe2wb_valid_i;
    logic                 exe2wb_rd_wr_i;
    logic [RF_AWIDTH-1:0] exe2wb_rd_addr_i;
    logic [XLEN-1:0]      exe2wb_rd_data_i;

    logic                 lsu2wb_valid_i;
    logic                 lsu2wb_ready_o;
    logic [RF_AWIDTH-1:0] lsu2wb_rd_addr_i;
    logic [XLEN-1:0]      lsu2wb_data_i;
    logic [2:0]           lsu2wb_ld_ops_i;
    logic [1:0]           lsu2wb_addr_lsb_i;

    logic                 wb2rf_rd_wr_req_o;
    logic [RF_AWIDTH-1:0] wb2rf_rd_addr_o;
    logic [XLEN-1:0]      wb2rf_rd_data_o;
    logic [CNT_W-1:0]     wb2id_lsu_pending_o;

    modport master (
        output exe2wb_valid_i, exe2wb_rd_wr_i, exe2wb_rd_addr_i, exe2wb_rd_data_i,
        output lsu2wb_valid_i, lsu2wb_rd_addr_i, lsu2wb_data_i, lsu2wb_ld_ops_i,
               lsu2wb_addr_lsb_i,
        input  lsu2wb_ready_o,
        input  wb2rf_rd_wr_req_o, wb2rf_rd_addr_o, wb2rf_rd_data_o, wb2id_lsu_pending_o
    );

    modport slave (
        input  exe2wb_valid_i, exe2wb_rd_wr_i, exe2wb_rd_addr_i, exe2wb_rd_data_i,
        input  lsu2wb_valid_i, lsu2wb_rd_addr_i, lsu2wb_data_i, lsu2wb_ld_ops_i,
               lsu2wb_addr_lsb_i,
        output lsu2wb_ready_o,
        output wb2rf_rd_wr_req_o, wb2rf_rd_addr_o, wb2rf_rd_data_o, wb2id_lsu_pending_o
    );

endinterface

// File: rtl/wb_lsu_fifo.sv
// In-order buffer for formatted loads that lost arbitration; entries can be
// invalidated in place by a younger execute write to the same rd.
module wb_lsu_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  wb_entry_s                 push_entry_i,
    input  logic                      pop_i,
    input  logic                      kill_i,
    input  logic [WB_RF_AWIDTH-1:0]   kill_addr_i,
    output wb_entry_s                 head_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_s        mem_q [DEPTH];
    wb_entry_s        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~full_o;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Killed entries keep their slot so retirement order is unchanged.
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && (mem_q[i].rd_addr == kill_addr_i)) begin
                mem_d[i].valid = 1'b0;
            end
        end
        if (do_push) begin
            mem_d[tail_q] = push_entry_i;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: arbitrates execute results, buffered loads and bypassed
// loads onto a registered register-file write port.
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN          = WB_XLEN,
    parameter int RF_AWIDTH     = WB_RF_AWIDTH,
    parameter int LSU_BUF_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(LSU_BUF_DEPTH) + 1;

    logic                 exe_wr;
    logic                 ld_acc;
    logic                 ld_kill;
    logic                 bypass;
    logic                 pop;
    logic                 push;
    wb_entry_s            ld_entry;
    wb_entry_s            head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CNT_W-1:0]     fifo_count;

    logic                 wr_req_q, wr_req_d;
    logic [RF_AWIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]      data_q, data_d;

    assign bus.lsu2wb_ready_o = rst_n & ~fifo_full;

    assign exe_wr  = bus.exe2wb_valid_i & bus.exe2wb_rd_wr_i;
    assign ld_acc  = bus.lsu2wb_valid_i & bus.lsu2wb_ready_o;
    // A same-cycle execute write is younger than the incoming load: drop the load.
    assign ld_kill = exe_wr & ld_acc & (bus.lsu2wb_rd_addr_i == bus.exe2wb_rd_addr_i);

    assign ld_entry.valid   = 1'b1;
    assign ld_entry.rd_addr = bus.lsu2wb_rd_addr_i;
    assign ld_entry.data    = fmt_load(bus.lsu2wb_data_i, bus.lsu2wb_ld_ops_i,
                                       bus.lsu2wb_addr_lsb_i);

    assign pop    = ~exe_wr & ~fifo_empty;
    assign bypass = ~exe_wr & fifo_empty & ld_acc;
    assign push   = ld_acc & ~bypass & ~ld_kill;

    wb_lsu_fifo #(
        .DEPTH (LSU_BUF_DEPTH)
    ) u_lsu_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (ld_entry),
        .pop_i        (pop),
        .kill_i       (exe_wr),
        .kill_addr_i  (bus.exe2wb_rd_addr_i),
        .head_o       (head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .count_o      (fifo_count)
    );

    always_comb begin
        wr_req_d = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        if (exe_wr) begin
            wr_req_d = (bus.exe2wb_rd_addr_i != '0);
            addr_d   = bus.exe2wb_rd_addr_i;
            data_d   = bus.exe2wb_rd_data_i;
        end else if (pop) begin
            wr_req_d = head.valid & (head.rd_addr != '0);
            addr_d   = head.rd_addr;
            data_d   = head.data;
        end else if (bypass) begin
            wr_req_d = (ld_entry.rd_addr != '0);
            addr_d   = ld_entry.rd_addr;
            data_d   = ld_entry.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_req_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_req_q <= wr_req_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign bus.wb2rf_rd_wr_req_o   = wr_req_q;
    assign bus.wb2rf_rd_addr_o     = addr_q;
    assign bus.wb2rf_rd_data_o     = data_q;
    assign bus.wb2id_lsu_pending_o = fifo_count;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: table of single-cycle vectors plus hand-written
// reset, full-buffer and reset-with-pending-load sequences.
module tb_wb_unit;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    wb_unit_if bus ();

    wb_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        exe_v;
        logic        exe_wr;
        logic [4:0]  exe_rd;
        logic [31:0] exe_d;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [31:0] ld_d;
        logic [2:0]  ld_ops;
        logic [1:0]  ld_lsb;
        logic        e_req;
        logic        chk_ad;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_pend;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic ew, input logic [4:0] erd,
                         input logic [31:0] ed, input logic lv, input logic [4:0] lrd,
                         input logic [31:0] ld, input logic [2:0] lops, input logic [1:0] llsb);
        bus.exe2wb_valid_i    = ev;
        bus.exe2wb_rd_wr_i    = ew;
        bus.exe2wb_rd_addr_i  = erd;
        bus.exe2wb_rd_data_i  = ed;
        bus.lsu2wb_valid_i    = lv;
        bus.lsu2wb_rd_addr_i  = lrd;
        bus.lsu2wb_data_i     = ld;
        bus.lsu2wb_ld_ops_i   = lops;
        bus.lsu2wb_addr_lsb_i = llsb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd2, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic req, input logic [4:0] addr,
                           input logic [31:0] data, input logic [1:0] pend);
        chk({nm, " req"}, 32'(bus.wb2rf_rd_wr_req_o), 32'(req));
        if (req) begin
            chk({nm, " addr"}, 32'(bus.wb2rf_rd_addr_o), 32'(addr));
            chk({nm, " data"}, bus.wb2rf_rd_data_o, data);
        end
        chk({nm, " pend"}, 32'(bus.wb2id_lsu_pending_o), 32'(pend));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;

        //           ev  ew  erd  edata         lv  lrd  ldata         ops   lsb   req chk addr  data           pend rdy
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        3'd0,2'd0, 1'b0,1'b0,5'd0, 32'h0,        2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd5, 32'h0000_8000,3'd0,2'd1, 1'b1,1'b1,5'd5, 32'hFFFF_FF80,2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd5, 32'h0000_8000,3'd4,2'd1, 1'b1,1'b1,5'd5, 32'h0000_0080,2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd6, 32'h8001_0000,3'd1,2'd2, 1'b1,1'b1,5'd6, 32'hFFFF_8001,2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd6, 32'h1234_F00D,3'd5,2'd0, 1'b1,1'b1,5'd6, 32'h0000_F00D,2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd6, 32'h9ABC_0000,3'd1,2'd3, 1'b1,1'b1,5'd6, 32'hFFFF_9ABC,2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd8, 32'hDEAD_BEEF,3'd7,2'd0, 1'b1,1'b1,5'd8, 32'hDEAD_BEEF,2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd8, 32'h7F00_0000,3'd0,2'd3, 1'b1,1'b1,5'd8, 32'h0000_007F,2'd0,1'b1});
        // collision: exe first, buffered load next cycle
        vecs.push_back('{1'b1,1'b1,5'd3, 32'h11,       1'b1,5'd4, 32'h22,       3'd2,2'd0, 1'b1,1'b1,5'd3, 32'h11,       2'd1,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        3'd2,2'd0, 1'b1,1'b1,5'd4, 32'h22,       2'd0,1'b1});
        // kill of a buffered entry
        vecs.push_back('{1'b1,1'b1,5'd10,32'h99,       1'b1,5'd7, 32'h55,       3'd2,2'd0, 1'b1,1'b1,5'd10,32'h99,       2'd1,1'b1});
        vecs.push_back('{1'b1,1'b1,5'd7, 32'hAA,       1'b0,5'd0, 32'h0,        3'd2,2'd0, 1'b1,1'b1,5'd7, 32'hAA,       2'd1,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        3'd2,2'd0, 1'b0,1'b0,5'd0, 32'h0,        2'd0,1'b1});
        // same-cycle kill: load discarded, outputs then hold
        vecs.push_back('{1'b1,1'b1,5'd9, 32'h33,       1'b1,5'd9, 32'h44,       3'd2,2'd0, 1'b1,1'b1,5'd9, 32'h33,       2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        3'd2,2'd0, 1'b0,1'b1,5'd9, 32'h33,       2'd0,1'b1});
        // x0 destinations
        vecs.push_back('{1'b1,1'b1,5'd0, 32'h77,       1'b0,5'd0, 32'h0,        3'd2,2'd0, 1'b0,1'b0,5'd0, 32'h0,        2'd0,1'b1});
        vecs.push_back('{1'b1,1'b1,5'd2, 32'h1,        1'b1,5'd0, 32'h5,        3'd2,2'd0, 1'b1,1'b1,5'd2, 32'h1,        2'd1,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        3'd2,2'd0, 1'b0,1'b0,5'd0, 32'h0,        2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd0, 32'h6,        3'd2,2'd0, 1'b0,1'b0,5'd0, 32'h0,        2'd0,1'b1});
        // exe valid without rd_wr is idle, load bypasses
        vecs.push_back('{1'b1,1'b0,5'd11,32'hBAD,      1'b1,5'd12,32'h66,       3'd2,2'd0, 1'b1,1'b1,5'd12,32'h66,       2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        3'd2,2'd0, 1'b0,1'b1,5'd12,32'h66,       2'd0,1'b1});
        vecs.push_back('{1'b0,1'b1,5'd12,32'h777,      1'b0,5'd0, 32'h0,        3'd2,2'd0, 1'b0,1'b1,5'd12,32'h66,       2'd0,1'b1});

        // reset with active inputs for two cycles
        drive(1'b1, 1'b1, 5'd1, 32'h1234, 1'b1, 5'd2, 32'h5678, 3'd2, 2'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("rst%0d req", c), 32'(bus.wb2rf_rd_wr_req_o), 32'h0);
            chk($sformatf("rst%0d addr", c), 32'(bus.wb2rf_rd_addr_o), 32'h0);
            chk($sformatf("rst%0d data", c), bus.wb2rf_rd_data_o, 32'h0);
            chk($sformatf("rst%0d pend", c), 32'(bus.wb2id_lsu_pending_o), 32'h0);
            chk($sformatf("rst%0d rdy", c), 32'(bus.lsu2wb_ready_o), 32'h0);
        end
        rst_n = 1'b1;
        idle();
        tick();
        chk_out("post_rst", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("post_rst rdy", 32'(bus.lsu2wb_ready_o), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].exe_v, vecs[i].exe_wr, vecs[i].exe_rd, vecs[i].exe_d,
                  vecs[i].ld_v, vecs[i].ld_rd, vecs[i].ld_d, vecs[i].ld_ops, vecs[i].ld_lsb);
            tick();
            chk($sformatf("v%0d req", i), 32'(bus.wb2rf_rd_wr_req_o), 32'(vecs[i].e_req));
            if (vecs[i].chk_ad) begin
                chk($sformatf("v%0d addr", i), 32'(bus.wb2rf_rd_addr_o), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d data", i), bus.wb2rf_rd_data_o, vecs[i].e_data);
            end
            chk($sformatf("v%0d pend", i), 32'(bus.wb2id_lsu_pending_o), 32'(vecs[i].e_pend));
            chk($sformatf("v%0d rdy", i), 32'(bus.lsu2wb_ready_o), 32'(vecs[i].e_rdy));
        end

        // full buffer: continuous exe with a load offered every cycle
        idle();
        tick();
        drive(1'b1, 1'b1, 5'd13, 32'h100, 1'b1, 5'd14, 32'h1, 3'd2, 2'd0);
        tick();
        chk_out("full c1", 1'b1, 5'd13, 32'h100, 2'd1);
        chk("full c1 rdy", 32'(bus.lsu2wb_ready_o), 32'h1);
        drive(1'b1, 1'b1, 5'd13, 32'h101, 1'b1, 5'd15, 32'h2, 3'd2, 2'd0);
        tick();
        chk_out("full c2", 1'b1, 5'd13, 32'h101, 2'd2);
        chk("full c2 rdy", 32'(bus.lsu2wb_ready_o), 32'h0);
        drive(1'b1, 1'b1, 5'd13, 32'h102, 1'b1, 5'd16, 32'h3, 3'd2, 2'd0);
        tick();
        chk_out("full c3", 1'b1, 5'd13, 32'h102, 2'd2);
        chk("full c3 rdy", 32'(bus.lsu2wb_ready_o), 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'h3, 3'd2, 2'd0);
        tick();
        chk_out("full c4", 1'b1, 5'd14, 32'h1, 2'd1);
        chk("full c4 rdy", 32'(bus.lsu2wb_ready_o), 32'h1);
        tick();
        chk_out("full c5", 1'b1, 5'd15, 32'h2, 2'd1);
        idle();
        tick();
        chk_out("full c6", 1'b1, 5'd16, 32'h3, 2'd0);
        tick();
        chk_out("full c7", 1'b0, 5'd0, 32'h0, 2'd0);

        // reset while a load is buffered: the load is lost
        drive(1'b1, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 3'd2, 2'd0);
        tick();
        chk_out("pre_rst2", 1'b1, 5'd1, 32'hA1, 2'd1);
        rst_n = 1'b0;
        tick();
        chk_out("rst2", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("rst2 rdy", 32'(bus.lsu2wb_ready_o), 32'h0);
        rst_n = 1'b1;
        idle();
        tick();
        chk_out("post_rst2", 1'b0, 5'd0, 32'h0, 2'd0);
        tick();
        chk_out("post_rst2b", 1'b0, 5'd0, 32'h0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
